axi_rdarbiter: RTL and testbench

- Round-robin arbiter that shares one downstream AXI read channel (AR + R) among NM upstream requesters.
- Typical downstream targets: the bus-error responder or any single read-only AXI slave.
- Holds one burst outstanding at a time. The grant locks from AR acceptance until the final R beat handshakes, then passes to the next requester.
- Sits between requester-side masters and a single slave in small interconnects.

---
 rtl/axi_rdarbiter_pkg.sv | 19 +
 rtl/axi_rdarbiter_rr_pick.sv | 38 +++
 rtl/axi_rdarbiter.sv | 159 +++++++++++++++
 tb/tb_axi_rdarbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rdarbiter_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
// No logic; state encoding and AXI response codes only.
// Imported by the arbiter top and its testbench.
package axi_rdarbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Width of the optional beat counter (ARLEN+1 can reach 256).
  localparam int BEAT_W = 9;

endpackage

// File: rtl/axi_rdarbiter_rr_pick.sv
// Round-robin priority pick: first request after the last winner, wrapping modulo NM.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
  parameter int NM = 2
) (
  input  logic [NM-1:0]         i_req,
  input  logic [$clog2(NM)-1:0] i_last,
  output logic [NM-1:0]         o_grant,
  output logic [$clog2(NM)-1:0] o_idx,
  output logic                  o_any
);

  localparam int GW = $clog2(NM);

  // Candidate index last+k, reduced modulo NM without a divider.
  logic [GW:0] w_cand;

  // Scan lw+1 .. lw+NM and keep the first asserted request.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NM; k++) begin
      w_cand = {1'b0, i_last} + (GW+1)'(k);
      if (w_cand >= (GW+1)'(NM)) begin
        w_cand = w_cand - (GW+1)'(NM);
      end
      if (!o_any && i_req[w_cand[GW-1:0]]) begin
        o_any                     = 1'b1;
        o_idx                     = w_cand[GW-1:0];
        o_grant[w_cand[GW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rdarbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR+R) among NM requesters, one burst outstanding.
// Latency: AR accepted in cycle N drives M_AXI_ARVALID in N+1; R passes through combinationally; one IDLE bubble per burst.
// Backpressure: AR held until M_AXI_ARREADY; M_AXI_RREADY follows the granted lane's RREADY. Option macro: AXI_RDARBITER_BEATCHK_EN.
module axi_rdarbiter
  import axi_rdarbiter_pkg::*;
#(
  parameter int NM               = 2,
  parameter int C_AXI_ID_WIDTH   = 2,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESET,
  input  logic [NM-1:0]                  S_AXI_ARVALID,
  output logic [NM-1:0]                  S_AXI_ARREADY,
  input  logic [NM*C_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [NM*8-1:0]                S_AXI_ARLEN,
  output logic [NM-1:0]                  S_AXI_RVALID,
  input  logic [NM-1:0]                  S_AXI_RREADY,
  output logic [NM*C_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [NM*C_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [NM-1:0]                  S_AXI_RLAST,
  output logic [NM*2-1:0]                S_AXI_RRESP,
  output logic                           M_AXI_ARVALID,
  input  logic                           M_AXI_ARREADY,
  output logic [C_AXI_ID_WIDTH-1:0]      M_AXI_ARID,
  output logic [7:0]                     M_AXI_ARLEN,
  input  logic                           M_AXI_RVALID,
  output logic                           M_AXI_RREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]      M_AXI_RID,
  input  logic [C_AXI_DATA_WIDTH-1:0]    M_AXI_RDATA,
  input  logic                           M_AXI_RLAST,
  input  logic [1:0]                     M_AXI_RRESP
);

  localparam int IW = C_AXI_ID_WIDTH;
  localparam int GW = $clog2(NM);

  state_t          r_state;
  state_t          w_next;
  logic [GW-1:0]   r_g;
  logic [GW-1:0]   r_lw;
  logic            r_arvalid;
  logic [IW-1:0]   r_arid;
  logic [7:0]      r_arlen;

  logic [NM-1:0]   w_grant;
  logic [GW-1:0]   w_idx;
  logic            w_any;
  logic            w_ar_hs;
  logic            w_r_hs;
  logic            w_last;

  rr_pick #(.NM(NM)) u_pick (
    .i_req   (S_AXI_ARVALID),
    .i_last  (r_lw),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Reset gates the accept so no ARREADY leaks out while reset is held.
  assign w_ar_hs       = (r_state == IDLE) && w_any && !S_AXI_ARESET;
  assign S_AXI_ARREADY = w_ar_hs ? w_grant : '0;

  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_ARID    = r_arid;
  assign M_AXI_ARLEN   = r_arlen;

  assign M_AXI_RREADY  = (r_state == DATA) && S_AXI_RREADY[r_g];
  assign w_r_hs        = M_AXI_RVALID && M_AXI_RREADY;

  assign S_AXI_RID     = {NM{M_AXI_RID}};
  assign S_AXI_RDATA   = {NM{M_AXI_RDATA}};
  assign S_AXI_RRESP   = {NM{M_AXI_RRESP}};
  assign S_AXI_RLAST   = {NM{w_last}};

  // Route downstream RVALID to the granted lane only, and only during DATA.
  always_comb begin
    S_AXI_RVALID = '0;
    if (r_state == DATA) begin
      S_AXI_RVALID[r_g] = M_AXI_RVALID;
    end
  end

`ifdef AXI_RDARBITER_BEATCHK_EN
  logic [BEAT_W-1:0] r_beats;
  logic              r_rlast_err;

  // Burst end comes from our own beat count, not the slave's RLAST.
  assign w_last = (r_beats == BEAT_W'(1));

  // Beat counter: load ARLEN+1 on accept, count down per R handshake.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_beats <= '0;
    end else if (w_ar_hs) begin
      r_beats <= {1'b0, S_AXI_ARLEN[w_idx*8 +: 8]} + BEAT_W'(1);
    end else if (w_r_hs) begin
      r_beats <= r_beats - BEAT_W'(1);
    end
  end

  // Sticky flag for a slave whose RLAST disagrees with the beat count.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_rlast_err <= 1'b0;
    end else if (w_r_hs && (M_AXI_RLAST != w_last)) begin
      r_rlast_err <= 1'b1;
    end
  end
`else
  assign w_last = M_AXI_RLAST;
`endif

  // State register.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: accept -> address phase -> data phase until the last beat handshakes.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_ar_hs)           w_next = ADDR;
      ADDR:    if (M_AXI_ARREADY)     w_next = DATA;
      DATA:    if (w_r_hs && w_last)  w_next = IDLE;
      default:                        w_next = IDLE;
    endcase
  end

  // Grant, last winner and the registered downstream AR payload.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_g       <= '0;
      r_lw      <= GW'(NM-1);
      r_arvalid <= 1'b0;
      r_arid    <= '0;
      r_arlen   <= '0;
    end else begin
      if (w_ar_hs) begin
        r_g       <= w_idx;
        r_arvalid <= 1'b1;
        r_arid    <= S_AXI_ARID[w_idx*IW +: IW];
        r_arlen   <= S_AXI_ARLEN[w_idx*8 +: 8];
      end
      if ((r_state == ADDR) && M_AXI_ARREADY) begin
        r_arvalid <= 1'b0;
      end
      if ((r_state == DATA) && w_r_hs && w_last) begin
        r_lw <= r_g;
      end
    end
  end

endmodule

// File: tb/tb_axi_rdarbiter.sv
// Scoreboard bench for axi_rdarbiter with NM=2: requester and slave models, expected AR/R queues.
// Expectations are pushed in expected grant order when requests are queued.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_axi_rdarbiter;
  import axi_rdarbiter_pkg::*;

  localparam int NM = 2;
  localparam int IW = 2;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     S_AXI_ARVALID;
  logic [NM-1:0]     S_AXI_ARREADY;
  logic [NM*IW-1:0]  S_AXI_ARID;
  logic [NM*8-1:0]   S_AXI_ARLEN;
  logic [NM-1:0]     S_AXI_RVALID;
  logic [NM-1:0]     S_AXI_RREADY;
  logic [NM*IW-1:0]  S_AXI_RID;
  logic [NM*DW-1:0]  S_AXI_RDATA;
  logic [NM-1:0]     S_AXI_RLAST;
  logic [NM*2-1:0]   S_AXI_RRESP;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;
  logic [IW-1:0]     M_AXI_ARID;
  logic [7:0]        M_AXI_ARLEN;
  logic              M_AXI_RVALID;
  logic              M_AXI_RREADY;
  logic [IW-1:0]     M_AXI_RID;
  logic [DW-1:0]     M_AXI_RDATA;
  logic              M_AXI_RLAST;
  logic [1:0]        M_AXI_RRESP;

  always #5 clk = ~clk;

  axi_rdarbiter #(.NM(NM), .C_AXI_ID_WIDTH(IW), .C_AXI_DATA_WIDTH(DW)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_ARID    (S_AXI_ARID),
    .S_AXI_ARLEN   (S_AXI_ARLEN),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .S_AXI_RID     (S_AXI_RID),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RLAST   (S_AXI_RLAST),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_ARID    (M_AXI_ARID),
    .M_AXI_ARLEN   (M_AXI_ARLEN),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY),
    .M_AXI_RID     (M_AXI_RID),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RLAST   (M_AXI_RLAST),
    .M_AXI_RRESP   (M_AXI_RRESP)
  );

  typedef struct packed { logic [IW-1:0] id; logic [7:0] len; } req_t;
  typedef struct packed { logic lane; logic [IW-1:0] id; logic [7:0] len; } ar_t;
  typedef struct packed {
    logic lane; logic [IW-1:0] id; logic [DW-1:0] dat; logic [1:0] resp; logic last;
  } beat_t;

  req_t  rq0[$];
  req_t  rq1[$];
  req_t  sq[$];
  ar_t   q_sgrant[$];
  ar_t   q_mar[$];
  beat_t q_beat[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int sbeat = 0;
  int ar_stall = 0;
  int last_hs = -1;
  int hs_cnt = 0;
  int pcnt = 0;
  logic chk_period = 1'b0;
  logic arv_next = 1'b0;
  logic bad_last = 1'b0;
  logic stall_pat = 1'b0;
  logic stall_lane = 1'b0;
  logic [3:0] pat = 4'b1001;
  logic [NM-1:0] hs_s = '0;
  logic hs_mar = 1'b0;
  logic hs_mr = 1'b0;
  req_t mar_cap;

  function automatic logic [DW-1:0] mkdat(input logic [IW-1:0] id, input logic [7:0] len, input int b);
    return {6'd0, id, len, b[15:0]};
  endfunction

  function automatic logic [1:0] mkresp(input logic [IW-1:0] id);
    return id[0] ? SLVERR : OKAY;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic enqueue(input logic lane, input logic [IW-1:0] id, input logic [7:0] len);
    req_t r;
    r.id = id; r.len = len;
    if (lane) rq1.push_back(r); else rq0.push_back(r);
    q_sgrant.push_back({lane, id, len});
    q_mar.push_back({lane, id, len});
    for (int b = 0; b <= int'(len); b++)
      q_beat.push_back({lane, id, mkdat(id, len, b), mkresp(id), (b == int'(len))});
  endtask

  task automatic monitor();
    ar_t   ea;
    beat_t eb;
    logic [NM-1:0] one;
    logic  l;
    if (arv_next) begin
      check("arvalid_lat", M_AXI_ARVALID, 1);
      arv_next = 1'b0;
    end
    if (S_AXI_ARVALID == '1) check("arrdy_onehot", ($countones(S_AXI_ARREADY) <= 1), 1);
    hs_s = S_AXI_ARVALID & S_AXI_ARREADY;
    for (int n = 0; n < NM; n++) begin
      if (hs_s[n]) begin
        if (q_sgrant.size() > 0) begin
          ea = q_sgrant.pop_front();
          check("grant_lane", n, ea.lane);
          check("m_arvalid_pre", M_AXI_ARVALID, 0);
          arv_next = 1'b1;
          if (chk_period && last_hs >= 0) check("ar_period", cyc - last_hs, 3);
          last_hs = cyc;
        end else check("grant_q", q_sgrant.size(), 1);
      end
    end
    hs_mar = M_AXI_ARVALID & M_AXI_ARREADY;
    mar_cap.id = M_AXI_ARID; mar_cap.len = M_AXI_ARLEN;
    if (M_AXI_ARVALID) begin
      if (q_mar.size() > 0) begin
        check("m_arid", M_AXI_ARID, q_mar[0].id);
        check("m_arlen", M_AXI_ARLEN, q_mar[0].len);
        if (!M_AXI_ARREADY) check("s_arrdy_stall", S_AXI_ARREADY, 0);
        if (hs_mar) void'(q_mar.pop_front());
      end else check("mar_q", q_mar.size(), 1);
    end
    hs_mr = M_AXI_RVALID & M_AXI_RREADY;
    if (M_AXI_RVALID && q_beat.size() > 0) begin
      l = q_beat[0].lane;
      one = 1;
      check("s_rvalid", S_AXI_RVALID, one << l);
      check("m_rready", M_AXI_RREADY, S_AXI_RREADY[l]);
    end
    for (int n = 0; n < NM; n++) begin
      if (S_AXI_RVALID[n] && S_AXI_RREADY[n]) begin
        hs_cnt++;
        if (q_beat.size() > 0) begin
          eb = q_beat.pop_front();
          check("r_lane", n, eb.lane);
          check("r_id", S_AXI_RID[n*IW +: IW], eb.id);
          check("r_data", S_AXI_RDATA[n*DW +: DW], eb.dat);
          check("r_resp", S_AXI_RRESP[n*2 +: 2], eb.resp);
          check("r_last", S_AXI_RLAST[n], eb.last);
        end else check("beat_q", q_beat.size(), 1);
      end
    end
  endtask

  task automatic drive();
    if (hs_s[0]) void'(rq0.pop_front());
    if (hs_s[1]) void'(rq1.pop_front());
    S_AXI_ARVALID = '0; S_AXI_ARID = '0; S_AXI_ARLEN = '0;
    if (rq0.size() > 0) begin
      S_AXI_ARVALID[0] = 1'b1; S_AXI_ARID[0 +: IW] = rq0[0].id; S_AXI_ARLEN[0 +: 8] = rq0[0].len;
    end
    if (rq1.size() > 0) begin
      S_AXI_ARVALID[1] = 1'b1; S_AXI_ARID[IW +: IW] = rq1[0].id; S_AXI_ARLEN[8 +: 8] = rq1[0].len;
    end
    M_AXI_ARREADY = (ar_stall == 0);
    if (M_AXI_ARVALID && ar_stall > 0) ar_stall--;
    if (hs_mr && sq.size() > 0) begin
      sbeat++;
      if (sbeat > int'(sq[0].len)) begin
        void'(sq.pop_front());
        sbeat = 0;
      end
    end
    if (hs_mar) sq.push_back(mar_cap);
    M_AXI_RVALID = (sq.size() > 0);
    M_AXI_RID = '0; M_AXI_RDATA = '0; M_AXI_RRESP = '0; M_AXI_RLAST = 1'b0;
    if (sq.size() > 0) begin
      M_AXI_RID   = sq[0].id;
      M_AXI_RDATA = mkdat(sq[0].id, sq[0].len, sbeat);
      M_AXI_RRESP = mkresp(sq[0].id);
      M_AXI_RLAST = bad_last ? (sbeat == int'(sq[0].len) - 1) : (sbeat == int'(sq[0].len));
    end
    S_AXI_RREADY = '1;
    if (stall_pat) begin
      S_AXI_RREADY = {NM{~pat[pcnt % 4]}};
      S_AXI_RREADY[stall_lane] = pat[pcnt % 4];
      pcnt++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic run_done(input int budget);
    int k = 0;
    while ((q_beat.size() + q_mar.size() + q_sgrant.size()) > 0 && k < budget) begin
      step();
      k++;
    end
    check("drain", q_beat.size() + q_mar.size() + q_sgrant.size(), 0);
    step();
    step();
  endtask

  initial begin
    int k;
    rst = 1'b1;
    S_AXI_ARVALID = '1; S_AXI_ARID = '0; S_AXI_ARLEN = '0; S_AXI_RREADY = '1;
    M_AXI_ARREADY = 1'b1; M_AXI_RVALID = 1'b0; M_AXI_RID = '0; M_AXI_RDATA = '0;
    M_AXI_RLAST = 1'b0; M_AXI_RRESP = '0;
    #2;
    check("rst_arready", S_AXI_ARREADY, 0);
    check("rst_rvalid", S_AXI_RVALID, 0);
    check("rst_m_rready", M_AXI_RREADY, 0);
    check("rst_m_arvalid", M_AXI_ARVALID, 0);
    check("rst_m_arid", M_AXI_ARID, 0);
    check("rst_m_arlen", M_AXI_ARLEN, 0);
    S_AXI_ARVALID = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive();

    // Contention: lw resets to 1, so lane 0 first, then strict alternation.
    chk_period = 1'b1; last_hs = -1;
    enqueue(1'b0, 2'd0, 8'd0);
    enqueue(1'b1, 2'd1, 8'd0);
    enqueue(1'b0, 2'd2, 8'd0);
    enqueue(1'b1, 2'd3, 8'd0);
    run_done(200);
    chk_period = 1'b0;

    // Single requester, 4-beat burst.
    enqueue(1'b0, 2'd1, 8'd3);
    run_done(200);

    // AR backpressure; lane 0 waits behind lane 1 (lw=0).
    ar_stall = 5;
    enqueue(1'b1, 2'd2, 8'd1);
    enqueue(1'b0, 2'd3, 8'd0);
    run_done(200);

    // R stall on lane 1 with RREADY pattern 1,0,0,1.
    stall_lane = 1'b1; stall_pat = 1'b1; pcnt = 0; hs_cnt = 0;
    enqueue(1'b1, 2'd1, 8'd7);
    run_done(300);
    check("r_stall_beats", hs_cnt, 8);
    stall_pat = 1'b0;

    // Reset during beat 2 of a lane-1 burst that follows a lane-0 burst.
    enqueue(1'b0, 2'd1, 8'd1);
    run_done(200);
    enqueue(1'b1, 2'd2, 8'd3);
    k = 0;
    while (q_beat.size() > 3 && k < 100) begin
      step();
      k++;
    end
    check("pre_rst_beats", q_beat.size(), 3);
    rq0.push_back('{id: 2'd3, len: 8'd0});
    S_AXI_ARVALID[0] = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_arready", S_AXI_ARREADY, 0);
    check("mid_rst_rvalid", S_AXI_RVALID, 0);
    check("mid_rst_m_rready", M_AXI_RREADY, 0);
    check("mid_rst_m_arvalid", M_AXI_ARVALID, 0);
    rq0.delete(); rq1.delete(); sq.delete();
    q_sgrant.delete(); q_mar.delete(); q_beat.delete();
    sbeat = 0; hs_s = '0; hs_mar = 1'b0; hs_mr = 1'b0; arv_next = 1'b0; last_hs = -1;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    enqueue(1'b0, 2'd1, 8'd0);
    enqueue(1'b1, 2'd2, 8'd0);
    run_done(200);

`ifdef AXI_RDARBITER_BEATCHK_EN
    // Slave ends the 3-beat burst one beat early; the arbiter keeps its own count.
    bad_last = 1'b1;
    enqueue(1'b0, 2'd1, 8'd2);
    run_done(200);
    bad_last = 1'b0;
    check("rlast_err", dut.r_rlast_err, 1);
    check("state_idle", dut.r_state, IDLE);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
